seq_mult4: RTL and testbench
============================

Name: seq_mult4

Overview:
- Sequential shift-and-add unsigned multiplier.
- Consumes the team's 4-bit ripple adder as its per-iteration adder: one partial-product add per clock.
- Produces a 2*WIDTH-bit product for downstream datapath logic.
- Start/done handshake; one multiplication in flight at a time.

Parameters:
- WIDTH, 4, operand width in bits. The adder datapath is fixed at 4 bits, so only 4 is supported.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiplication; sampled on rising edge of clk
- a  input  WIDTH  multiplicand, captured when start is accepted
- b  input  WIDTH  multiplier, captured when start is accepted
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse: product valid and newly updated
- product  output  2*WIDTH  registered result; holds until the next completion

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state clears immediately on rst=1, independent of clk.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - product = 0
  - internal mcand, acc, cnt = 0
- States: IDLE, RUN, DONE (2-bit encoding, defined in the package).
- IDLE:
  - start=1 at an edge: mcand <= a; acc <= {WIDTH'b0, b}; cnt <= 0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), once per edge:
  - If acc[0]=1: {c, s} = acc[2W-1:W] + mcand via the 4-bit adder with cin=0. Else {c, s} = {0, acc[2W-1:W]}.
  - acc <= {c, s, acc[W-1:1]} (logical right shift, carry enters MSB); cnt <= cnt+1.
  - On the edge where cnt == WIDTH-1: load product with the shifted acc value, then go to DONE.
  - start is ignored while in RUN. a and b may change freely after acceptance.
- DONE (done=1, busy=0) lasts exactly one cycle:
  - start=1: accepted exactly as in IDLE (back-to-back operation), go to RUN.
  - start=0: go to IDLE.
- Latency: start accepted at edge k; product updates and done rises at edge k+WIDTH (k+4); done falls at edge k+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles.
- Arithmetic: unsigned only. Carry-out of the adder is never discarded. Max result 15*15 = 225 = 8'hE1 fits in 2*WIDTH bits.
- Boundary conditions:
  - Operand 0 gives product 0, with the same latency.
  - b=0 means no add in any iteration.
  - The counter never wraps: it resets on every accept.
- Reset mid-RUN: abort immediately. product returns to 0, done is not asserted. The next start after rst deasserts runs normally.
- start held high continuously: a new operation is accepted in every DONE cycle, so done pulses every 5 cycles.
- product is stable except at completion edges and at reset.

Decomposition:
- Package seq_mult_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - WIDTH default constant
- Sub-module: instantiate the team's existing adder4bits once for the per-iteration add (a=acc high half, b=mcand, cin=0, sum/cout feed the shift).
- Control FSM, counter and shift register stay in seq_mult4.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 for 10 cycles -> busy=0, done=0, product=8'h00 throughout.
- Single op: start=1 for one cycle with a=4'd9, b=4'd6 -> busy=1 for 4 cycles; done=1 on the 4th edge after accept; product=8'd54, held afterwards.
- Maximum and carry path: a=15, b=15 -> product=8'hE1 (225). a=15, b=0 and a=0, b=15 -> product=0 with the same latency.
- Start ignored while busy: accept a=3, b=5; during RUN pulse start with a=7, b=7 -> only one done pulse; product=8'd15.
- Back-to-back: start held high with operand pairs (2,3), (4,5), (15,1) -> done pulses every 5 cycles; product sequence 6, 20, 15.
- Async reset mid-op: accept a=12, b=11; assert rst 2 cycles later between clock edges -> outputs clear immediately, no done pulse. Then a=1, b=1 -> product=1. Finish with an exhaustive 256-pair sweep against a reference a*b.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_mult_pkg;

   // Default operand width; the adder datapath is fixed at 4 bits.
   localparam int DEF_WIDTH = 4;

   // Control states of the multiplier FSM.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder4bits.sv
// 4-bit ripple-carry adder: sum/cout = a + b + cin.
// Latency: combinational.
// Backpressure: none.
module adder4bits (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry;

   // Ripple the carry through four full-adder stages.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[4];

endmodule

// File: rtl/seq_mult4.sv
// Unsigned shift-and-add multiplier, one partial-product add per clock.
// Latency: done/product update WIDTH edges after start is accepted; one result per WIDTH+1 cycles.
// Backpressure: none; start is only accepted in IDLE or DONE and ignored while busy.
module seq_mult4
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,  // only 4 is supported by the adder datapath
   parameter int CNT_W = 3           // 2**CNT_W must exceed WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   state_t               state;
   state_t               state_nxt;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [CNT_W-1:0]     cnt;

   logic [WIDTH-1:0]     add_sum;
   logic                 add_cout;
   logic [WIDTH:0]       step;      // {carry, sum} chosen for this iteration
   logic [2*WIDTH-1:0]   acc_shift;
   logic                 accept;
   logic                 last_iter;

   // Partial-product adder: high half of the accumulator plus the multiplicand.
   adder4bits u_add (
      .a    (acc[2*WIDTH-1:WIDTH]),
      .b    (mcand),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Select add-or-pass by the current multiplier LSB, then shift right with the carry entering the MSB.
   always_comb begin
      step = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (acc[0]) begin
         step = {add_cout, add_sum};
      end
      acc_shift = {step, acc[WIDTH-1:1]};
   end

   assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
   assign last_iter = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs; DONE lasts one cycle and can re-accept immediately.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Operand capture, iteration datapath and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand   <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         mcand <= a;
         acc   <= {{WIDTH{1'b0}}, b};
         cnt   <= '0;
      end else if (state == S_RUN) begin
         acc <= acc_shift;
         cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (last_iter) begin
            product <= acc_shift;
         end
      end
   end

endmodule

// File: tb/tb_seq_mult4.sv
// Self-checking bench for seq_mult4 against a behavioural a*b model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_mult4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int checks = 0;
   int errors = 0;

   seq_mult4 #(.WIDTH(4), .CNT_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an accepted op keeps the unit busy for 4 cycles,
   // then shows a*b with a one-cycle done.
   int         m_left = 0;
   bit         m_done = 1'b0;
   logic [7:0] m_prod = '0;
   logic [7:0] m_pend = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0;
         m_done = 1'b0;
         m_prod = '0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_prod = m_pend;
            m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            m_pend = 8'(a * b);
            m_left = 4;
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("product", 32'(product), 32'(m_prod));
   end

   // One operation; expects done 4 edges after accept and the literal product.
   task automatic do_op(input logic [3:0] xa, input logic [3:0] xb, input logic [7:0] lit,
                        input bit poke_start, input bit hold_chk);
      int busy_cnt = 0;
      int done_at  = 0;
      int extra    = 0;
      start = 1'b1; a = xa; b = xb;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
         end
         if (poke_start) begin
            start = (i == 2);
            if (i == 2) begin a = 4'd7; b = 4'd7; end
         end
         if (busy) busy_cnt++;
         if (done) begin done_at = i; break; end
      end
      start = 1'b0;
      if (done_at == 0) begin
         check("op_timeout", 32'd0, 32'd1);
      end else begin
         check("done_latency", 32'(done_at), 32'd5);
         check("busy_cycles", 32'(busy_cnt), 32'd4);
         check("product_lit", 32'(product), 32'(lit));
         check("model_lit", 32'(m_prod), 32'(lit));
      end
      if (hold_chk) begin
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) extra++;
         end
         check("no_extra_done", 32'(extra), 32'd0);
         check("product_held", 32'(product), 32'(lit));
      end
   endtask

   logic [3:0] bb_a [3] = '{4'd2, 4'd4, 4'd15};
   logic [3:0] bb_b [3] = '{4'd3, 4'd5, 4'd1};
   logic [7:0] bb_p [3] = '{8'd6, 8'd20, 8'd15};

   initial begin
      int n;
      int last_t;
      int cyc;
      // Reset, then idle.
      repeat (2) @(negedge clk);
      check("rst_product", 32'(product), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      do_op(4'd9, 4'd6, 8'd54, 1'b0, 1'b1);
      do_op(4'd15, 4'd15, 8'hE1, 1'b0, 1'b1);
      do_op(4'd15, 4'd0, 8'd0, 1'b0, 1'b1);
      do_op(4'd0, 4'd15, 8'd0, 1'b0, 1'b1);
      do_op(4'd3, 4'd5, 8'd15, 1'b1, 1'b1);

      // Back-to-back with start held high.
      n = 0; last_t = 0; cyc = 0;
      start = 1'b1; a = bb_a[0]; b = bb_b[0];
      while (n < 3 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            check("b2b_product", 32'(product), 32'(bb_p[n]));
            if (n > 0) check("b2b_interval", 32'(cyc - last_t), 32'd5);
            last_t = cyc;
            n++;
            if (n < 3) begin a = bb_a[n]; b = bb_b[n]; end
            else start = 1'b0;
         end
      end
      start = 1'b0;
      check("b2b_count", 32'(n), 32'd3);
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of an operation.
      start = 1'b1; a = 4'd12; b = 4'd11;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_product", 32'(product), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      do_op(4'd1, 4'd1, 8'd1, 1'b0, 1'b1);

      // Exhaustive sweep.
      for (int i = 0; i < 256; i++) begin
         do_op(4'(i >> 4), 4'(i), 8'((i >> 4) * (i & 15)), 1'b0, 1'b0);
         @(negedge clk);
      end

      // Random start/operand traffic, checked by the per-cycle model compare.
      for (int i = 0; i < 600; i++) begin
         start = 1'($urandom_range(0, 1));
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      start = 1'b0;
      repeat (8) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
